spr_rom_sched: RTL and testbench
================================

Name: spr_rom_sched

Overview:
- Schedules all accesses to the sprite graphics ROM, which in the FPGA build lives in external SDRAM instead of a dedicated 512k×32 ROM.
- Shares one SDRAM client port between two requesters: the sprite fetch path (k051960 decoded CA → 32-bit chunky word feeding the chunky-to-planar routing into k051937) and the ROM loader that fills the region at boot.
- Provides a one-entry hit register so repeated fetches of the same word cost no memory cycle.

Parameters:
- AW, 19, word address width of the sprite ROM (512k words).
- DW, 32, data width.
- LD_STARVE, 4, consecutive sprite grants allowed while a loader request waits before the loader is forced through.

Ports:
- clk_main  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- spr_strobe  in  1  one-cycle pulse: spr_addr holds a new fetch address.
- spr_addr  in  AW  word address ({OC[4], CA[17:10], CA_DEC, CA[3]}).
- spr_data  out  DW  last fetched word, chunky order; held between fetches.
- spr_valid  out  1  one-cycle pulse when spr_data updates.
- ld_req  in  1  loader write request; level, held until ld_ack.
- ld_addr  in  AW  loader word address.
- ld_data  in  DW  loader write data.
- ld_ack  out  1  one-cycle pulse: loader write completed.
- mem_req  out  1  SDRAM request; level, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
- mem_addr  out  AW  SDRAM word address.
- mem_din  out  DW  write data to SDRAM.
- mem_dout  in  DW  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- overrun_cnt  out  8  saturating count of sprite strobes lost while a fetch was pending.

Behaviour:
- Reset values: all outputs 0; hit register invalid; starvation counter 0; state IDLE.
- States:
  - IDLE: no memory access in progress.
  - SPR_RD: mem_req high, mem_we = 0.
  - LD_WR: mem_req high, mem_we = 1.
- Strobe capture: spr_strobe loads a pending register (addr plus pending flag) in every state.
- IDLE, pending sprite fetch:
  - Hit (hit register valid and tag == pending addr): spr_valid pulses next cycle, spr_data unchanged, pending cleared, no mem_req. Strobe at cycle t → spr_valid at t+1.
  - Miss: go to SPR_RD with mem_addr = pending addr. mem_req is registered, so strobe at t → mem_req at t+1.
- SPR_RD on mem_ack:
  - spr_data ← mem_dout; tag ← addr; hit register valid; spr_valid pulses the cycle after mem_ack.
  - Return to IDLE.
- IDLE, ld_req only: go to LD_WR with mem_addr/mem_din = ld_addr/ld_data.
- LD_WR on mem_ack:
  - ld_ack pulses the cycle after mem_ack.
  - If ld_addr == tag, the hit register is invalidated.
  - Return to IDLE.
- Arbitration when both sprite pending and ld_req are present in IDLE:
  - Sprite wins unless the starvation counter == LD_STARVE, in which case the loader wins.
  - Counter increments on each sprite grant made while ld_req is high; clears on loader grant or when ld_req is low.
- Strobe while pending already set (busy or not yet granted):
  - The newer address overwrites the pending address.
  - overrun_cnt increments, saturating at 255.
  - A strobe arriving during SPR_RD for the in-flight address does not count as an overrun.
- A strobe in the same cycle as mem_ack: the completion is processed and the new strobe becomes pending. It is not an overrun, because pending was cleared at grant.
- mem_req, mem_we, mem_addr and mem_din do not change while mem_req is high.
- Reset mid-transaction:
  - Returns to IDLE immediately; any in-flight ack is ignored.
  - SDRAM controller is reset by the same signal.
- Width: address compare is a full AW-bit equality; no partial tags.

Decomposition:
- Shared package spr_rom_pkg holds:
  - localparam AW/DW defaults;
  - state enum {IDLE, SPR_RD, LD_WR};
  - the 8-bit overrun saturation limit.
- One natural sub-module: spr_rom_hitreg, which holds the tag, valid flag and data, with load, invalidate-on-match and compare output. Everything else stays in the top.

Test Plan:
- Miss then hit:
  - Stimulus: strobe addr 0x12345; mem acks 3 cycles after mem_req with 0xDEADBEEF.
  - Required: mem_req rises at t+1; spr_valid one cycle after ack with data 0xDEADBEEF.
  - Stimulus: second strobe, same addr.
  - Required: spr_valid at t+1 with no mem_req.
- Loader invalidates hit:
  - Stimulus: cache 0x00010, then loader writes 0x00010 = 0xCAFEF00D; strobe 0x00010 again.
  - Required: ld_ack pulses; new read issued; spr_data = 0xCAFEF00D.
- Starvation bound:
  - Stimulus: ld_req held while sprite strobes (distinct addrs) arrive every grant.
  - Required: loader granted after exactly 4 sprite reads; ld_ack follows.
- Overrun:
  - Stimulus: with mem_ack delayed 10 cycles, strobes 0x100, 0x200, 0x300 at 1-cycle spacing.
  - Required: reads of 0x100 then 0x300 only; overrun_cnt = 1.
- Saturation:
  - Stimulus: 300 overruns.
  - Required: overrun_cnt = 255.
- Reset mid-read:
  - Stimulus: assert reset while mem_req is high.
  - Required: all outputs 0 immediately; a later mem_ack produces no spr_valid.

Source files
------------

// File: rtl/spr_rom_pkg.sv
// ---------------------------------------------------------------------------
// spr_rom_pkg
// Shared definitions for the sprite ROM scheduler: default address/data
// widths, the loader starvation bound, the overrun counter ceiling and the
// scheduler state encoding.
// ---------------------------------------------------------------------------
package spr_rom_pkg;

   localparam int         AW_DEF        = 19;
   localparam int         DW_DEF        = 32;
   localparam int         LD_STARVE_DEF = 4;
   localparam logic [7:0] OVR_MAX       = 8'hFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SPR_RD = 2'd1,
      LD_WR  = 2'd2
   } state_e;

endpackage

// File: rtl/spr_rom_sched_hitreg.sv
// ---------------------------------------------------------------------------
// spr_rom_hitreg
// One-entry hit register for the sprite fetch path. Holds the last word read
// from the sprite ROM together with its full word address (tag) and a valid
// flag. A loader write to the tagged address invalidates the entry so the
// next fetch goes back to memory.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   load_i       capture load_tag_i/load_data_i and mark valid
//   load_tag_i   address of the word being loaded
//   load_data_i  word being loaded
//   inval_i      a loader write completed at inval_addr_i
//   inval_addr_i address written by the loader
//   cmp_addr_i   address to test for a hit
//   hit_o        entry valid and tag equals cmp_addr_i
//   data_o       stored word (held between loads)
// ---------------------------------------------------------------------------
module spr_rom_hitreg
   import spr_rom_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          load_i,
   input  logic [AW-1:0] load_tag_i,
   input  logic [DW-1:0] load_data_i,
   input  logic          inval_i,
   input  logic [AW-1:0] inval_addr_i,
   input  logic [AW-1:0] cmp_addr_i,
   output logic          hit_o,
   output logic [DW-1:0] data_o
);

   logic [AW-1:0] tag_q,   tag_d;
   logic [DW-1:0] data_q,  data_d;
   logic          valid_q, valid_d;

   // Load wins over invalidation; the two never coincide because loads come
   // from sprite reads and invalidations from loader writes.
   always_comb begin
      tag_d   = tag_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (load_i) begin
         tag_d   = load_tag_i;
         data_d  = load_data_i;
         valid_d = 1'b1;
      end else if (inval_i && (inval_addr_i == tag_q)) begin
         valid_d = 1'b0;
      end
   end

   // Entry storage; reset leaves the entry invalid with zero data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tag_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         tag_q   <= tag_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign hit_o  = valid_q && (cmp_addr_i == tag_q);
   assign data_o = data_q;

endmodule

// File: rtl/spr_rom_sched.sv
// ---------------------------------------------------------------------------
// spr_rom_sched
// Schedules every access to the sprite graphics ROM held in external SDRAM.
// One SDRAM client port is shared between the sprite fetch path and the boot
// ROM loader. A one-entry hit register answers repeated fetches of the same
// word without a memory cycle.
//
// Ports:
//   clk_main     system clock, rising edge
//   reset        asynchronous active-high reset
//   spr_strobe   one-cycle pulse, spr_addr holds a new fetch address
//   spr_addr     sprite word address
//   spr_data     last fetched word, held between fetches
//   spr_valid    one-cycle pulse when spr_data updates
//   ld_req       loader write request, held until ld_ack
//   ld_addr      loader word address
//   ld_data      loader write data
//   ld_ack       one-cycle pulse, loader write completed
//   mem_req      SDRAM request, held until mem_ack
//   mem_we       1 = write, 0 = read
//   mem_addr     SDRAM word address
//   mem_din      SDRAM write data
//   mem_dout     SDRAM read data, valid with mem_ack
//   mem_ack      one-cycle completion pulse
//   overrun_cnt  saturating count of sprite strobes lost while pending
// ---------------------------------------------------------------------------
module spr_rom_sched
   import spr_rom_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int LD_STARVE = LD_STARVE_DEF
) (
   input  logic          clk_main,
   input  logic          reset,
   input  logic          spr_strobe,
   input  logic [AW-1:0] spr_addr,
   output logic [DW-1:0] spr_data,
   output logic          spr_valid,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ack,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   input  logic          mem_ack,
   output logic [7:0]    overrun_cnt
);

   localparam int SW = $clog2(LD_STARVE + 2);
   localparam logic [SW-1:0] STARVE_LIMIT = SW'(LD_STARVE);

   state_e        state_q,    state_d;
   logic          pend_q,     pend_d;
   logic [AW-1:0] pendAddr_q, pendAddr_d;
   logic          memReq_q,   memReq_d;
   logic          memWe_q,    memWe_d;
   logic [AW-1:0] memAddr_q,  memAddr_d;
   logic [DW-1:0] memDin_q,   memDin_d;
   logic          sprValid_q, sprValid_d;
   logic          ldAck_q,    ldAck_d;
   logic [SW-1:0] starve_q,   starve_d;
   logic [7:0]    overrun_q,  overrun_d;

   logic          curPend;
   logic [AW-1:0] curAddr;
   logic          ldReqEff;
   logic          sprWins;
   logic          hit;
   logic          hitLoad;
   logic          hitInval;

   // A strobe arriving in IDLE is acted on in the same cycle, so the fetch
   // request (or hit pulse) appears one cycle after the strobe rather than
   // two. The newest strobe always supersedes an older pending address.
   assign curPend = pend_q | spr_strobe;
   assign curAddr = spr_strobe ? spr_addr : pendAddr_q;

   // The loader keeps ld_req high through the ld_ack cycle; masking it there
   // stops the same write from being granted twice.
   assign ldReqEff = ld_req && !ldAck_q;

   spr_rom_hitreg #(
      .AW (AW),
      .DW (DW)
   ) u_hitreg (
      .clk_i        (clk_main),
      .rst_i        (reset),
      .load_i       (hitLoad),
      .load_tag_i   (memAddr_q),
      .load_data_i  (mem_dout),
      .inval_i      (hitInval),
      .inval_addr_i (memAddr_q),
      .cmp_addr_i   (curAddr),
      .hit_o        (hit),
      .data_o       (spr_data)
   );

   // Next-state logic: strobe capture and overrun counting happen in every
   // state; the case statement handles grants and memory completions. The
   // memory request fields are only rewritten on a grant, so they stay
   // stable for the whole time mem_req is high.
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pendAddr_d = pendAddr_q;
      memReq_d   = memReq_q;
      memWe_d    = memWe_q;
      memAddr_d  = memAddr_q;
      memDin_d   = memDin_q;
      sprValid_d = 1'b0;
      ldAck_d    = 1'b0;
      starve_d   = starve_q;
      overrun_d  = overrun_q;
      hitLoad    = 1'b0;
      hitInval   = 1'b0;
      sprWins    = 1'b0;

      if (spr_strobe) begin
         pend_d     = 1'b1;
         pendAddr_d = spr_addr;
         if (pend_q && !((state_q == SPR_RD) && (spr_addr == memAddr_q))
             && (overrun_q != OVR_MAX)) begin
            overrun_d = overrun_q + 8'd1;
         end
      end

      case (state_q)
         IDLE: begin
            sprWins = curPend && !(ldReqEff && (starve_q == STARVE_LIMIT));
            if (sprWins) begin
               pend_d = 1'b0;
               if (ldReqEff && (starve_q != STARVE_LIMIT)) begin
                  starve_d = starve_q + 1'b1;
               end
               if (hit) begin
                  sprValid_d = 1'b1;
               end else begin
                  state_d   = SPR_RD;
                  memReq_d  = 1'b1;
                  memWe_d   = 1'b0;
                  memAddr_d = curAddr;
               end
            end else if (ldReqEff) begin
               starve_d  = '0;
               state_d   = LD_WR;
               memReq_d  = 1'b1;
               memWe_d   = 1'b1;
               memAddr_d = ld_addr;
               memDin_d  = ld_data;
            end
         end
         SPR_RD: begin
            if (mem_ack) begin
               hitLoad    = 1'b1;
               sprValid_d = 1'b1;
               memReq_d   = 1'b0;
               state_d    = IDLE;
            end
         end
         LD_WR: begin
            if (mem_ack) begin
               hitInval = 1'b1;
               ldAck_d  = 1'b1;
               memReq_d = 1'b0;
               memWe_d  = 1'b0;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d  = IDLE;
            memReq_d = 1'b0;
            memWe_d  = 1'b0;
         end
      endcase

      if (!ld_req) begin
         starve_d = '0;
      end
   end

   // State register; reset abandons any in-flight access immediately.
   always_ff @(posedge clk_main or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         pend_q     <= 1'b0;
         pendAddr_q <= '0;
         memReq_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memDin_q   <= '0;
         sprValid_q <= 1'b0;
         ldAck_q    <= 1'b0;
         starve_q   <= '0;
         overrun_q  <= '0;
      end else begin
         state_q    <= state_d;
         pend_q     <= pend_d;
         pendAddr_q <= pendAddr_d;
         memReq_q   <= memReq_d;
         memWe_q    <= memWe_d;
         memAddr_q  <= memAddr_d;
         memDin_q   <= memDin_d;
         sprValid_q <= sprValid_d;
         ldAck_q    <= ldAck_d;
         starve_q   <= starve_d;
         overrun_q  <= overrun_d;
      end
   end

   assign spr_valid   = sprValid_q;
   assign ld_ack      = ldAck_q;
   assign mem_req     = memReq_q;
   assign mem_we      = memWe_q;
   assign mem_addr    = memAddr_q;
   assign mem_din     = memDin_q;
   assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_spr_rom_sched.sv
// ---------------------------------------------------------------------------
// tb_spr_rom_sched
// Self-checking bench for spr_rom_sched. Expected memory transactions and
// sprite words are queued as stimulus is issued; an SDRAM model and an
// output monitor pop and compare them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_spr_rom_sched;

   localparam int AW = 19;
   localparam int DW = 32;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } txn_t;

   logic          clk_main = 1'b0;
   logic          reset    = 1'b1;
   logic          spr_strobe = 1'b0;
   logic [AW-1:0] spr_addr   = '0;
   logic [DW-1:0] spr_data;
   logic          spr_valid;
   logic          ld_req  = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;
   logic          ld_ack;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   logic          mem_ack;
   logic [7:0]    overrun_cnt;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   txn_t          expTxn[$];
   logic [DW-1:0] expSpr[$];
   int            ldAckExp = 0;

   logic [DW-1:0] memArr [logic [AW-1:0]];
   int            ackDelay  = 3;
   bit            modelEn   = 1'b1;
   int            forceReq  = 0;
   int            forceDone = 0;
   logic [DW-1:0] forceData = '0;

   spr_rom_sched dut (
      .clk_main    (clk_main),
      .reset       (reset),
      .spr_strobe  (spr_strobe),
      .spr_addr    (spr_addr),
      .spr_data    (spr_data),
      .spr_valid   (spr_valid),
      .ld_req      (ld_req),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_ack      (ld_ack),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_dout    (mem_dout),
      .mem_ack     (mem_ack),
      .overrun_cnt (overrun_cnt)
   );

   // 10 ns clock and a cycle counter used for latency measurements.
   always #5 clk_main = ~clk_main;
   always @(posedge clk_main) cyc++;

   task automatic checkOutput(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] rdWord(input logic [AW-1:0] a);
      if (memArr.exists(a)) return memArr[a];
      return 32'h5A00_0000 | {13'd0, a};
   endfunction

   // Output monitor: every spr_valid / ld_ack pulse must match a queued
   // expectation.
   initial begin
      forever begin
         @(negedge clk_main);
         if (!reset && spr_valid) begin
            if (expSpr.size() == 0)
               checkOutput("spr_valid_unexpected", {31'd0, spr_valid}, 32'd0);
            else
               checkOutput("spr_data", spr_data, expSpr.pop_front());
         end
         if (!reset && ld_ack) begin
            if (ldAckExp == 0)
               checkOutput("ld_ack_unexpected", {31'd0, ld_ack}, 32'd0);
            else
               ldAckExp--;
         end
      end
   end

   // SDRAM model: checks each new request against the expected transaction
   // queue, checks the request stays stable, then acks after ackDelay cycles.
   initial begin
      txn_t got;
      txn_t want;
      logic stable;
      mem_ack  = 1'b0;
      mem_dout = '0;
      forever begin
         @(negedge clk_main);
         if (forceReq != forceDone) begin
            mem_ack  = 1'b1;
            mem_dout = forceData;
            @(negedge clk_main);
            mem_ack  = 1'b0;
            mem_dout = '0;
            forceDone++;
         end else if (modelEn && !reset && mem_req) begin
            got.we   = mem_we;
            got.addr = mem_addr;
            got.din  = mem_din;
            stable   = 1'b1;
            if (expTxn.size() == 0) begin
               checkOutput("txn_unexpected", {13'd0, got.addr}, 32'hFFFF_FFFF);
            end else begin
               want = expTxn.pop_front();
               checkOutput("txn_we", {31'd0, got.we}, {31'd0, want.we});
               checkOutput("txn_addr", {13'd0, got.addr}, {13'd0, want.addr});
               if (want.we) checkOutput("txn_din", got.din, want.din);
            end
            if (got.we) memArr[got.addr] = got.din;
            repeat (ackDelay) begin
               @(negedge clk_main);
               if (mem_req !== 1'b1 || mem_we !== got.we ||
                   mem_addr !== got.addr || mem_din !== got.din)
                  stable = 1'b0;
            end
            checkOutput("txn_stable", {31'd0, stable}, 32'd1);
            mem_ack  = 1'b1;
            mem_dout = got.we ? 32'h0 : rdWord(got.addr);
            @(negedge clk_main);
            mem_ack  = 1'b0;
            mem_dout = '0;
         end
      end
   end

   task automatic pushRd(input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = 1'b0; t.addr = a; t.din = '0;
      expTxn.push_back(t);
      expSpr.push_back(d);
   endtask

   task automatic pushWr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      txn_t t;
      t.we = 1'b1; t.addr = a; t.din = d;
      expTxn.push_back(t);
      ldAckExp++;
   endtask

   task automatic applyStimulus(input logic [AW-1:0] a, output int t);
      @(posedge clk_main); #1;
      spr_strobe = 1'b1;
      spr_addr   = a;
      t          = cyc;
      @(posedge clk_main); #1;
      spr_strobe = 1'b0;
   endtask

   task automatic resetPulse();
      @(posedge clk_main); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk_main);
      #1 reset = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      for (n = 0; n < 300; n++) begin
         @(negedge clk_main);
         if (expSpr.size() == 0 && expTxn.size() == 0 && ldAckExp == 0 && !mem_req) break;
      end
      checkOutput({name, "_spr_left"}, expSpr.size(), 0);
      checkOutput({name, "_txn_left"}, expTxn.size(), 0);
      checkOutput({name, "_ldack_left"}, ldAckExp, 0);
   endtask

   task automatic waitReadHigh(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk_main);
         if (mem_req && !mem_we) begin ok = 1'b1; break; end
      end
      checkOutput({name, "_read_timeout"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic waitReqLow(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk_main);
         if (!mem_req) begin ok = 1'b1; break; end
      end
      checkOutput({name, "_low_timeout"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic waitLdAck(input string name);
      bit ok = 1'b0;
      for (int n = 0; n < 80; n++) begin
         @(negedge clk_main);
         if (ld_ack) begin ok = 1'b1; break; end
      end
      checkOutput({name, "_ldack_timeout"}, {31'd0, ok}, 32'd1);
      @(posedge clk_main); #1;
      ld_req = 1'b0;
   endtask

   task automatic ldWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pushWr(a, d);
      @(posedge clk_main); #1;
      ld_req  = 1'b1;
      ld_addr = a;
      ld_data = d;
      waitLdAck("ldwrite");
   endtask

   // Directed test sequence.
   initial begin
      int  t;
      int  tv;
      bit  seen;
      memArr[19'h12345] = 32'hDEADBEEF;

      // Reset state.
      #2;
      checkOutput("rst_mem_req",  {31'd0, mem_req}, 32'd0);
      checkOutput("rst_mem_we",   {31'd0, mem_we}, 32'd0);
      checkOutput("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
      checkOutput("rst_spr_valid", {31'd0, spr_valid}, 32'd0);
      checkOutput("rst_spr_data", spr_data, 32'd0);
      checkOutput("rst_ld_ack",   {31'd0, ld_ack}, 32'd0);
      checkOutput("rst_overrun",  {24'd0, overrun_cnt}, 32'd0);
      repeat (3) @(posedge clk_main);
      #1 reset = 1'b0;

      // Miss then hit.
      ackDelay = 3;
      pushRd(19'h12345, 32'hDEADBEEF);
      applyStimulus(19'h12345, t);
      @(negedge clk_main);
      checkOutput("miss_req_t1", {31'd0, mem_req}, 32'd1);
      checkOutput("miss_addr", {13'd0, mem_addr}, 32'h0001_2345);
      tv = -1;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk_main);
         if (spr_valid) begin tv = cyc; break; end
      end
      checkOutput("miss_valid_latency", tv - t, 32'd5);
      expSpr.push_back(32'hDEADBEEF);
      applyStimulus(19'h12345, t);
      @(negedge clk_main);
      checkOutput("hit_valid_t1", {31'd0, spr_valid}, 32'd1);
      checkOutput("hit_no_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk_main);
      checkOutput("hit_no_req_later", {31'd0, mem_req}, 32'd0);
      drain("hit");

      // Loader invalidates the hit entry.
      pushRd(19'h00010, 32'h5A00_0010);
      applyStimulus(19'h00010, t);
      drain("cache10");
      ldWrite(19'h00010, 32'hCAFEF00D);
      drain("ldwr");
      pushRd(19'h00010, 32'hCAFEF00D);
      applyStimulus(19'h00010, t);
      @(negedge clk_main);
      checkOutput("inval_rereads", {31'd0, mem_req}, 32'd1);
      drain("reread");
      checkOutput("inval_data_held", spr_data, 32'hCAFEF00D);

      // Starvation bound: loader forced through after four sprite reads.
      ackDelay = 2;
      pushRd(19'h00400, 32'h5A00_0400);
      pushRd(19'h00401, 32'h5A00_0401);
      pushRd(19'h00402, 32'h5A00_0402);
      pushRd(19'h00403, 32'h5A00_0403);
      pushWr(19'h07000, 32'h1111_2222);
      pushRd(19'h00404, 32'h5A00_0404);
      expSpr.push_back(32'h0); expSpr.pop_back();
      @(posedge clk_main); #1;
      ld_req     = 1'b1;
      ld_addr    = 19'h07000;
      ld_data    = 32'h1111_2222;
      spr_strobe = 1'b1;
      spr_addr   = 19'h00400;
      @(posedge clk_main); #1;
      spr_strobe = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         waitReadHigh("starve");
         applyStimulus(19'h00400 + 19'(k), t);
         waitReqLow("starve");
      end
      waitLdAck("starve");
      drain("starve");

      // Overrun: 0x200 is superseded by 0x300 while 0x100 is in flight.
      resetPulse();
      checkOutput("ovr_reset", {24'd0, overrun_cnt}, 32'd0);
      ackDelay = 10;
      pushRd(19'h00100, 32'h5A00_0100);
      pushRd(19'h00300, 32'h5A00_0300);
      @(posedge clk_main); #1;
      spr_strobe = 1'b1; spr_addr = 19'h00100;
      @(posedge clk_main); #1;
      spr_addr = 19'h00200;
      @(posedge clk_main); #1;
      spr_addr = 19'h00300;
      @(posedge clk_main); #1;
      spr_strobe = 1'b0;
      drain("overrun");
      checkOutput("overrun_cnt_1", {24'd0, overrun_cnt}, 32'd1);

      // Saturation: memory never answers, every strobe after the second
      // overwrites a pending address.
      resetPulse();
      modelEn = 1'b0;
      for (int i = 0; i < 102; i++) begin
         @(posedge clk_main); #1;
         spr_strobe = 1'b1;
         spr_addr   = 19'h20000 + 19'(i);
      end
      @(posedge clk_main); #1;
      spr_strobe = 1'b0;
      @(negedge clk_main);
      checkOutput("overrun_cnt_100", {24'd0, overrun_cnt}, 32'd100);
      for (int i = 102; i < 302; i++) begin
         @(posedge clk_main); #1;
         spr_strobe = 1'b1;
         spr_addr   = 19'h20000 + 19'(i);
      end
      @(posedge clk_main); #1;
      spr_strobe = 1'b0;
      @(negedge clk_main);
      checkOutput("overrun_cnt_sat", {24'd0, overrun_cnt}, 32'd255);
      checkOutput("sat_req_pending", {31'd0, mem_req}, 32'd1);

      // Reset mid-read: outputs clear at once, a late ack is ignored.
      @(posedge clk_main); #1;
      reset = 1'b1;
      #1;
      checkOutput("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("midrst_mem_addr", {13'd0, mem_addr}, 32'd0);
      checkOutput("midrst_mem_din", mem_din, 32'd0);
      checkOutput("midrst_overrun", {24'd0, overrun_cnt}, 32'd0);
      checkOutput("midrst_spr_data", spr_data, 32'd0);
      repeat (2) @(posedge clk_main);
      #1 reset = 1'b0;
      forceData = 32'hBAD0BAD0;
      forceReq++;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk_main);
         if (spr_valid || mem_req) seen = 1'b1;
      end
      checkOutput("late_ack_ignored", {31'd0, seen}, 32'd0);
      checkOutput("late_ack_data", spr_data, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout actual=running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
